// File: rtl/eth_fcs_check.sv
// eth_fcs_check
//   Receive-side Ethernet FCS checker. Takes a GMII-style byte stream
//   (preamble/SFD already stripped), runs the reflected IEEE 802.3 CRC-32
//   over every byte including the trailing FCS, and checks that the final
//   register value is the magic residue 0xDEBB20E3. The frame is re-emitted
//   through a short delay line with first/last markers. One status pulse is
//   produced per frame.
//
//   Compile-time option: FCS_STRIP_EN
//     defined   : delay line depth 5, the 4 FCS bytes are never forwarded,
//                 out_last marks the last payload byte.
//     undefined : delay line depth 1, every byte (FCS included) is forwarded,
//                 out_last marks the final FCS byte.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rx_dv, rx_data      input byte stream, one contiguous rx_dv run per frame
//   out_data/out_valid  forwarded byte stream
//   out_first/out_last  frame boundary markers, qualified by out_valid
//   frame_done          1-cycle pulse, status outputs valid this cycle
//   frame_ok            no CRC error and no length error
//   crc_err, len_err    FCS mismatch / length outside [MIN_LEN, MAX_LEN]
//   frame_len           received byte count incl. FCS, saturating
module eth_fcs_check #(
    parameter int MAX_LEN = 1522,
    parameter int MIN_LEN = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_first,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] frame_len
);

`ifdef FCS_STRIP_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif

    localparam logic [3:0]  D_FILL      = 4'(D);
    localparam logic [31:0] MIN_L       = 32'(MIN_LEN);
    localparam logic [31:0] MAX_L       = 32'(MAX_LEN);
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;  // 0x04C11DB7 bit-reversed

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RX   = 2'd1;
    localparam logic [1:0] SKIP = 2'd2;

    // LSB-first byte update of the reflected CRC register
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY_R : 32'h0);
        return r;
    endfunction

    logic [1:0]     state;
    logic [31:0]    crc;
    logic [15:0]    cnt;
    logic [D*8-1:0] line;        // delay line, oldest byte in the top slot
    logic [D*8-1:0] line_nxt;
    logic [3:0]     fill;
    logic           first_pend;  // no byte of this frame emitted yet

    logic [7:0]  oldest;
    logic        line_full;
    logic [15:0] cnt_inc;
    logic        bad_crc;
    logic        bad_len;

    generate
        if (D == 1) begin : g_line1
            assign line_nxt = rx_data;
        end else begin : g_linen
            assign line_nxt = {line[D*8-9:0], rx_data};
        end
    endgenerate

    assign oldest    = line[D*8-1 -: 8];
    assign line_full = (fill == D_FILL);
    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign bad_crc   = (crc != CRC_RESIDUE);
    assign bad_len   = ({16'd0, cnt} < MIN_L) || ({16'd0, cnt} > MAX_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SKIP;
            crc        <= CRC_INIT;
            cnt        <= 16'd0;
            line       <= '0;
            fill       <= 4'd0;
            first_pend <= 1'b0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= 16'd0;
        end else begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= 16'd0;
            case (state)
                // frame in flight at reset release is dropped
                SKIP: if (!rx_dv) state <= IDLE;
                IDLE: if (rx_dv) begin
                    state      <= RX;
                    crc        <= crc_byte(CRC_INIT, rx_data);
                    cnt        <= 16'd1;
                    line       <= line_nxt;
                    fill       <= 4'd1;
                    first_pend <= 1'b1;
                end
                RX: if (rx_dv) begin
                    crc  <= crc_byte(crc, rx_data);
                    cnt  <= cnt_inc;
                    line <= line_nxt;
                    if (line_full) begin
                        out_data   <= oldest;
                        out_valid  <= 1'b1;
                        out_first  <= first_pend;
                        first_pend <= 1'b0;
                    end else begin
                        fill <= fill + 4'd1;
                    end
                end else begin
                    // end cycle: status out, last byte out, rest of line dropped
                    frame_done <= 1'b1;
                    crc_err    <= bad_crc;
                    len_err    <= bad_len;
                    frame_ok   <= !bad_crc && !bad_len;
                    frame_len  <= cnt;
                    if (line_full) begin
                        out_data  <= oldest;
                        out_valid <= 1'b1;
                        out_first <= first_pend;
                        out_last  <= 1'b1;
                    end
                    state      <= IDLE;
                    crc        <= CRC_INIT;
                    cnt        <= 16'd0;
                    fill       <= 4'd0;
                    first_pend <= 1'b0;
                end
                default: state <= SKIP;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fcs_check.sv
// tb_eth_fcs_check
//   Table of frames with known CRC-32 values (FCS appended LSB byte first),
//   expected status and forwarded bytes, plus hand-written sequences for
//   back-to-back frames and reset in the middle of a frame.
module tb_eth_fcs_check;

`ifdef FCS_STRIP_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif

    logic        clk;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic [15:0] frame_len;

    eth_fcs_check #(.MAX_LEN(16), .MIN_LEN(5)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data),
        .out_data(out_data), .out_valid(out_valid), .out_first(out_first),
        .out_last(out_last), .frame_done(frame_done), .frame_ok(frame_ok),
        .crc_err(crc_err), .len_err(len_err), .frame_len(frame_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [31:0][7:0] data;
        int              len;
        bit              exp_ok;
        bit              exp_crc;
        bit              exp_len;
        int              exp_flen;
    } vec_t;

    typedef struct { logic [7:0] d; bit f; bit l; } ob_t;
    typedef struct { bit ok; bit ce; bit le; logic [15:0] fl; } st_t;

    vec_t vt[10];
    ob_t  obq[$];
    st_t  stq[$];
    int   nvec = 0;
    int   nbad = 0;

    // capture DUT outputs on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid)  obq.push_back('{out_data, out_first, out_last});
            if (frame_done) stq.push_back('{frame_ok, crc_err, len_err, frame_len});
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // payload string, then nf bytes of fcs LSB first; xl flips bits of the final byte
    task automatic mk(input int i, input string nm, input string pl, input logic [31:0] fcs,
                      input int nf, input logic [7:0] xl, input bit ec, input bit el);
        int n;
        n = pl.len();
        vt[i].name = nm;
        vt[i].data = '0;
        for (int k = 0; k < n; k++) vt[i].data[k] = pl[k];
        for (int k = 0; k < nf; k++) vt[i].data[n+k] = fcs[8*k +: 8];
        vt[i].len = n + nf;
        vt[i].data[vt[i].len-1] = vt[i].data[vt[i].len-1] ^ xl;
        vt[i].exp_crc  = ec;
        vt[i].exp_len  = el;
        vt[i].exp_ok   = !ec && !el;
        vt[i].exp_flen = n + nf;
    endtask

    task automatic send_frame(input vec_t v, input int gap);
        for (int k = 0; k < v.len; k++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_data = v.data[k];
        end
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_data = 8'd0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic check_frames(input vec_t v, input int copies);
        int ne;
        int idx;
        repeat (3) @(negedge clk);
        ne = (v.len >= D) ? v.len - D + 1 : 0;
        chk($sformatf("%s.done_cnt", v.name), stq.size(), copies);
        chk($sformatf("%s.byte_cnt", v.name), obq.size(), ne * copies);
        for (int c = 0; c < copies; c++) begin
            if (c < stq.size()) begin
                chk($sformatf("%s[%0d].frame_ok", v.name, c), int'(stq[c].ok), int'(v.exp_ok));
                chk($sformatf("%s[%0d].crc_err", v.name, c), int'(stq[c].ce), int'(v.exp_crc));
                chk($sformatf("%s[%0d].len_err", v.name, c), int'(stq[c].le), int'(v.exp_len));
                chk($sformatf("%s[%0d].frame_len", v.name, c), int'(stq[c].fl), v.exp_flen);
            end
            for (int k = 0; k < ne; k++) begin
                idx = c * ne + k;
                if (idx < obq.size()) begin
                    chk($sformatf("%s[%0d].byte%0d", v.name, c, k), int'(obq[idx].d), int'(v.data[k]));
                    chk($sformatf("%s[%0d].first%0d", v.name, c, k), int'(obq[idx].f), int'(k == 0));
                    chk($sformatf("%s[%0d].last%0d", v.name, c, k), int'(obq[idx].l), int'(k == ne - 1));
                end
            end
        end
        obq.delete();
        stq.delete();
    endtask

    initial begin
        // known CRC-32 values of ASCII strings
        mk(0, "crc_ok_13",  "123456789",      32'hCBF43926, 4, 8'h00, 1'b0, 1'b0);
        mk(1, "bad_fcs",    "123456789",      32'hCBF43926, 4, 8'h01, 1'b1, 1'b0);
        mk(2, "runt3",      "",               32'h00030201, 3, 8'h00, 1'b1, 1'b1);
        mk(3, "min_len_5",  "a",              32'hE8B7BE43, 4, 8'h00, 1'b0, 1'b0);
        mk(4, "runt4",      "a",              32'hE8B7BE43, 3, 8'h00, 1'b1, 1'b1);
        mk(5, "abc",        "abc",            32'h352441C2, 4, 8'h00, 1'b0, 1'b0);
        mk(6, "hello_15",   "hello world",    32'h0D4A1185, 4, 8'h00, 1'b0, 1'b0);
        mk(7, "long_18",    "message digest", 32'h20159D7F, 4, 8'h00, 1'b0, 1'b1);
        mk(8, "long_30",    "abcdefghijklmnopqrstuvwxyz", 32'h4C2750BD, 4, 8'h00, 1'b0, 1'b1);
        mk(9, "single",     "",               32'h00000055, 1, 8'h00, 1'b1, 1'b1);

        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("reset.out_valid",  int'(out_valid),  0);
        chk("reset.frame_done", int'(frame_done), 0);
        chk("reset.out_first",  int'(out_first),  0);
        chk("reset.out_last",   int'(out_last),   0);
        chk("reset.frame_len",  int'(frame_len),  0);
        chk("reset.status",     int'({frame_ok, crc_err, len_err}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_frame(vt[i], 2);
            check_frames(vt[i], 1);
        end

        // two frames separated by the minimum one-cycle gap
        send_frame(vt[0], 1);
        send_frame(vt[0], 1);
        check_frames(vt[0], 2);

        // reset pulse in the middle of a frame, rx_dv stays high
        for (int k = 0; k < vt[0].len; k++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_data = vt[0].data[k];
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                rst = 1'b0;
                obq.delete();
                stq.delete();
            end
        end
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_data = 8'd0;
        repeat (4) @(negedge clk);
        chk("rst_mid.bytes", obq.size(), 0);
        chk("rst_mid.dones", stq.size(), 0);
        obq.delete();
        stq.delete();
        send_frame(vt[0], 2);
        check_frames(vt[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
